// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, constants and helpers for the systolic array sequencer
// Contents:
//   ctrl_state_t  sequencer state encoding
//   FP_ZERO       IEEE-754 +0.0, injected by the array datapath on idle operand lanes
//   drain_len()   cycles needed to flush the skewed array pipeline after the last operand
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } ctrl_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // The last operand enters PE[N-1][N-1] N-1 hops after PE[0][0] sees its last
  // operand along each axis, and the MAC pipeline then needs PE_LAT more cycles.
  function automatic int drain_len(input int n, input int pe_lat);
    return 2 * (n - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/systolic_if.sv
// rtl/systolic_if.sv - host/array-facing bundle of the systolic array sequencer
// Signals:
//   start, k_len               tile request and reduction length (host -> ctrl)
//   busy, done                 status and end-of-tile pulse (ctrl -> host)
//   pe_clr, pe_en              accumulator clear and array advance (ctrl -> array)
//   a_rd_en/a_rd_addr          per-row A buffer reads, row i at [i*K_W +: K_W]
//   b_rd_en/b_rd_addr          per-column B buffer reads, same packing
//   out_valid, out_row         result row presented (ctrl -> consumer)
//   out_ready                  consumer accepts the row (consumer -> ctrl)
//   stall                      freezes FEED/DRAIN, present only with SYSTOLIC_STALL_EN
// Modports: slave = sequencer, master = host/array/consumer side.
interface systolic_if #(
  parameter int N   = 4,
  parameter int K_W = 8
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic               start;
  logic [K_W-1:0]     k_len;
  logic               busy;
  logic               done;
  logic               pe_clr;
  logic               pe_en;
  logic [N-1:0]       a_rd_en;
  logic [N*K_W-1:0]   a_rd_addr;
  logic [N-1:0]       b_rd_en;
  logic [N*K_W-1:0]   b_rd_addr;
  logic               out_valid;
  logic [RW-1:0]      out_row;
  logic               out_ready;
`ifdef SYSTOLIC_STALL_EN
  logic               stall;
`endif

  modport slave (
`ifdef SYSTOLIC_STALL_EN
    input  stall,
`endif
    input  start, k_len, out_ready,
    output busy, done, pe_clr, pe_en,
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    output out_valid, out_row
  );

  modport master (
`ifdef SYSTOLIC_STALL_EN
    output stall,
`endif
    output start, k_len, out_ready,
    input  busy, done, pe_clr, pe_en,
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    input  out_valid, out_row
  );

endinterface

// File: rtl/systolic_skew_lane.sv
// rtl/systolic_skew_lane.sv - skewed operand-buffer read generator for one array row or column
// Ports:
//   t        in   feed counter (0-based FEED cycle)
//   idx      in   lane index; the lane starts reading idx cycles after lane 0
//   k_len    in   reduction length of the current tile
//   rd_en    out  lane reads this cycle (idx <= t < idx + k_len)
//   rd_addr  out  t - idx while reading, 0 otherwise
// Purely combinational; the caller gates the result with FEED activity.
module systolic_skew_lane #(
  parameter int K_W = 8,
  parameter int CW  = 11,
  parameter int IW  = 2
) (
  input  logic [CW-1:0]  t,
  input  logic [IW-1:0]  idx,
  input  logic [K_W-1:0] k_len,
  output logic           rd_en,
  output logic [K_W-1:0] rd_addr
);

  logic [CW-1:0] idx_w;
  logic [CW-1:0] end_w;

  assign idx_w   = CW'(idx);
  assign end_w   = idx_w + CW'(k_len);
  assign rd_en   = (t >= idx_w) && (t < end_w);
  // Within the window t - idx < k_len, so the truncation to K_W bits is lossless.
  assign rd_addr = rd_en ? K_W'(t - idx_w) : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for an NxN output-stationary floating-point systolic array
// Ports:
//   clk   in  clock
//   rst   in  asynchronous reset, active-low
//   io    systolic_if.slave: start/k_len/busy/done host handshake, pe_clr/pe_en array
//         control, skewed A/B buffer reads, out_valid/out_row/out_ready row readout
// Sequence: IDLE -> CLEAR -> FEED (k_len+N-1) -> DRAIN (2(N-1)+PE_LAT) -> READOUT -> DONE.
// Build option SYSTOLIC_STALL_EN: adds io.stall, which freezes FEED/DRAIN while high.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int PE_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  systolic_if.slave   io
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // One extra bit over k_len + N - 1 so the longest feed never wraps.
  localparam int CW = K_W + $clog2(N) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N, PE_LAT) - 1);

  ctrl_state_t    state;
  logic [CW-1:0]  cnt;
  logic [K_W-1:0] k_len_q;
  logic [IW-1:0]  row_q;
  logic           busy_q;
  logic           done_q;
  logic           pe_clr_q;
  logic           pe_en_q;
  logic           out_valid_q;

  logic           stall_w;
  logic           adv;
  logic           feed_go;
  logic [CW-1:0]  feed_last;

`ifdef SYSTOLIC_STALL_EN
  assign stall_w = io.stall;
`else
  assign stall_w = 1'b0;
`endif

  // Stall acts in the same cycle, so it gates the registered controls rather
  // than being folded into them.
  assign adv       = ~stall_w;
  assign feed_go   = (state == S_FEED) && adv;
  assign feed_last = CW'(k_len_q) + CW'(N - 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      k_len_q     <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_clr_q    <= 1'b0;
      pe_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (io.start) begin
            k_len_q <= io.k_len;
            cnt     <= '0;
            busy_q  <= 1'b1;
            if (io.k_len == '0) begin
              // Empty reduction: nothing to compute, report completion at once.
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state    <= S_CLEAR;
              pe_clr_q <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          pe_clr_q <= 1'b0;
          pe_en_q  <= 1'b1;
          cnt      <= '0;
          state    <= S_FEED;
        end

        S_FEED: begin
          if (adv) begin
            if (cnt == feed_last) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        S_DRAIN: begin
          if (adv) begin
            if (cnt == DRAIN_LAST) begin
              cnt         <= '0;
              pe_en_q     <= 1'b0;
              out_valid_q <= 1'b1;
              row_q       <= '0;
              state       <= S_READOUT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        S_READOUT: begin
          if (io.out_ready) begin
            if (row_q == IW'(N - 1)) begin
              out_valid_q <= 1'b0;
              row_q       <= '0;
              done_q      <= 1'b1;
              state       <= S_DONE;
            end else begin
              row_q <= row_q + IW'(1);
            end
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          pe_clr_q    <= 1'b0;
          pe_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.pe_clr    = pe_clr_q;
  assign io.pe_en     = pe_en_q & adv;
  assign io.out_valid = out_valid_q;
  assign io.out_row   = row_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic           a_en;
    logic           b_en;
    logic [K_W-1:0] a_addr;
    logic [K_W-1:0] b_addr;

    systolic_skew_lane #(.K_W(K_W), .CW(CW), .IW(IW)) u_row (
      .t       (cnt),
      .idx     (IW'(i)),
      .k_len   (k_len_q),
      .rd_en   (a_en),
      .rd_addr (a_addr)
    );

    systolic_skew_lane #(.K_W(K_W), .CW(CW), .IW(IW)) u_col (
      .t       (cnt),
      .idx     (IW'(i)),
      .k_len   (k_len_q),
      .rd_en   (b_en),
      .rd_addr (b_addr)
    );

    // Idle lanes present address 0; the array injects +0.0 there.
    assign io.a_rd_en[i]                = a_en & feed_go;
    assign io.a_rd_addr[i*K_W +: K_W]   = (a_en & feed_go) ? a_addr : '0;
    assign io.b_rd_en[i]                = b_en & feed_go;
    assign io.b_rd_addr[i*K_W +: K_W]   = (b_en & feed_go) ? b_addr : '0;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed self-checking bench for systolic_ctrl (N=4, K_W=8, PE_LAT=5)
module tb_systolic_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  systolic_if #(.N(4), .K_W(8)) io ();

  systolic_ctrl #(.N(4), .K_W(8), .PE_LAT(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int total = 0;
  int bad   = 0;

  logic       r_done [64];
  logic       r_busy [64];
  logic       r_clr  [64];
  logic       r_en   [64];
  logic       r_val  [64];
  logic [1:0] r_row  [64];
  logic [3:0] r_aen  [64];
  logic [3:0] r_ben  [64];
  logic [31:0] r_aaddr [64];
  logic [31:0] r_baddr [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one tile from cycle 0 (start) for ncyc cycles, recording outputs at each negedge.
  // Cycle c begins 1 time unit after posedge c; inputs are driven there.
  task automatic run_tile(input int k, input int bp_len, input int stall_len,
                          input bit ign_start, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      io.start     = (c == 0) || (ign_start && (c == 10 || c == 15));
      io.k_len     = (c == 0) ? 8'(k) : 8'hAA;
      io.out_ready = !(c >= 20 && c < 20 + bp_len);
`ifdef SYSTOLIC_STALL_EN
      io.stall     = (c >= 4 && c < 4 + stall_len);
`else
      if (stall_len != 0) check("stall_absent", 64'(stall_len), 64'd0);
`endif
      @(negedge clk);
      r_done[c]  = io.done;
      r_busy[c]  = io.busy;
      r_clr[c]   = io.pe_clr;
      r_en[c]    = io.pe_en;
      r_val[c]   = io.out_valid;
      r_row[c]   = io.out_row;
      r_aen[c]   = io.a_rd_en;
      r_ben[c]   = io.b_rd_en;
      r_aaddr[c] = io.a_rd_addr;
      r_baddr[c] = io.b_rd_addr;
      @(posedge clk);
      #1;
    end
    io.start     = 1'b0;
    io.out_ready = 1'b1;
`ifdef SYSTOLIC_STALL_EN
    io.stall     = 1'b0;
`endif
  endtask

  // Timetable of a k_len=3 tile with out_ready always high:
  // CLEAR 1, FEED 2-7, DRAIN 8-18, READOUT 19-22, DONE 23.
  task automatic check_basic(input string name);
    for (int c = 0; c < 26; c++) begin
      logic [3:0]  en;
      logic [31:0] addr;
      int t;
      en   = '0;
      addr = '0;
      t    = c - 2;
      for (int i = 0; i < 4; i++) begin
        if (c >= 2 && c <= 7 && t >= i && t < i + 3) begin
          en[i] = 1'b1;
          addr[i*8 +: 8] = 8'(t - i);
        end
      end
      check($sformatf("%s c%0d done", name, c), 64'(r_done[c]), 64'(c == 23));
      check($sformatf("%s c%0d busy", name, c), 64'(r_busy[c]), 64'(c >= 1 && c <= 23));
      check($sformatf("%s c%0d clr", name, c), 64'(r_clr[c]), 64'(c == 1));
      check($sformatf("%s c%0d pe_en", name, c), 64'(r_en[c]), 64'(c >= 2 && c <= 18));
      check($sformatf("%s c%0d valid", name, c), 64'(r_val[c]), 64'(c >= 19 && c <= 22));
      check($sformatf("%s c%0d row", name, c), 64'(r_row[c]),
            64'((c >= 19 && c <= 22) ? c - 19 : 0));
      check($sformatf("%s c%0d a_en", name, c), 64'(r_aen[c]), 64'(en));
      check($sformatf("%s c%0d a_addr", name, c), 64'(r_aaddr[c]), 64'(addr));
      check($sformatf("%s c%0d b_en", name, c), 64'(r_ben[c]), 64'(en));
      check($sformatf("%s c%0d b_addr", name, c), 64'(r_baddr[c]), 64'(addr));
    end
  endtask

  function automatic int count_done(input int ncyc);
    int n = 0;
    for (int c = 0; c < ncyc; c++) n += int'(r_done[c]);
    return n;
  endfunction

  initial begin
    int acc;
    io.start     = 1'b0;
    io.k_len     = '0;
    io.out_ready = 1'b1;
`ifdef SYSTOLIC_STALL_EN
    io.stall     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(io.busy), 64'd0);
    check("rst done", 64'(io.done), 64'd0);
    check("rst pe_en", 64'(io.pe_en), 64'd0);
    check("rst valid", 64'(io.out_valid), 64'd0);
    check("rst a_en", 64'(io.a_rd_en), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic tile.
    run_tile(3, 0, 0, 1'b0, 26);
    check_basic("basic");

    // Zero-length tile.
    run_tile(0, 0, 0, 1'b0, 5);
    check("zero done c0", 64'(r_done[0]), 64'd0);
    check("zero done c1", 64'(r_done[1]), 64'd1);
    check("zero busy c1", 64'(r_busy[1]), 64'd1);
    check("zero busy c2", 64'(r_busy[2]), 64'd0);
    acc = 0;
    for (int c = 0; c < 5; c++)
      acc += int'(r_clr[c]) + int'(r_en[c]) + int'(r_aen[c] != 0) + int'(r_ben[c] != 0);
    check("zero no activity", 64'(acc), 64'd0);

    // Backpressure on row 1 for 3 cycles.
    run_tile(3, 3, 0, 1'b0, 30);
    for (int c = 20; c < 24; c++) begin
      check($sformatf("bp c%0d row", c), 64'(r_row[c]), 64'd1);
      check($sformatf("bp c%0d valid", c), 64'(r_val[c]), 64'd1);
    end
    check("bp row2", 64'(r_row[24]), 64'd2);
    check("bp row3", 64'(r_row[25]), 64'd3);
    check("bp no early done", 64'(r_done[23]), 64'd0);
    check("bp done c26", 64'(r_done[26]), 64'd1);
    check("bp idle c27", 64'(r_busy[27]), 64'd0);
    check("bp done count", 64'(count_done(30)), 64'd1);

    // Starts during DRAIN are ignored.
    run_tile(3, 0, 0, 1'b1, 30);
    check("ign done c23", 64'(r_done[23]), 64'd1);
    check("ign done count", 64'(count_done(30)), 64'd1);
    check("ign busy c15", 64'(r_busy[15]), 64'd1);
    acc = 0;
    for (int c = 24; c < 30; c++) acc += int'(r_busy[c]);
    check("ign idle after", 64'(acc), 64'd0);

`ifdef SYSTOLIC_STALL_EN
    // Stall for cycles 4-5 while FEED is at t=2.
    run_tile(3, 0, 2, 1'b0, 28);
    check("stall pe_en c3", 64'(r_en[3]), 64'd1);
    check("stall pe_en c4", 64'(r_en[4]), 64'd0);
    check("stall pe_en c5", 64'(r_en[5]), 64'd0);
    check("stall a_en c3", 64'(r_aen[3]), 64'h3);
    check("stall a_addr c3", 64'(r_aaddr[3]), 64'h0000_0001);
    check("stall a_en c4", 64'(r_aen[4]), 64'd0);
    check("stall b_en c5", 64'(r_ben[5]), 64'd0);
    check("stall a_addr c4", 64'(r_aaddr[4]), 64'd0);
    check("stall a_en c6", 64'(r_aen[6]), 64'h7);
    check("stall a_addr c6", 64'(r_aaddr[6]), 64'h0000_0102);
    check("stall no early done", 64'(r_done[23]), 64'd0);
    check("stall done c25", 64'(r_done[25]), 64'd1);
`endif

    // Asynchronous reset in the middle of FEED.
    run_tile(3, 0, 0, 1'b0, 4);
    check("mid pe_en before rst", 64'(r_en[3]), 64'd1);
    rst = 1'b0;
    #1;
    check("mid rst busy", 64'(io.busy), 64'd0);
    check("mid rst pe_en", 64'(io.pe_en), 64'd0);
    check("mid rst a_en", 64'(io.a_rd_en), 64'd0);
    check("mid rst a_addr", 64'(io.a_rd_addr), 64'd0);
    check("mid rst b_en", 64'(io.b_rd_en), 64'd0);
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acc += int'(io.done);
    end
    check("mid rst no done", 64'(acc), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_tile(3, 0, 0, 1'b0, 26);
    check_basic("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an N×N output-stationary systolic array of floating-point PE multiply-accumulate cells (32-bit IEEE-754 operands).
- On a start handshake it does four things in order:
  - clears the PE accumulators;
  - drives skewed per-row A and per-column B operand-buffer reads for k_len steps;
  - waits for the array pipeline to drain;
  - hands results out row by row under valid/ready.
- Sits between the host/command block and the PE array plus its operand buffers.

Parameters:
- N, 4, array dimension (rows = columns).
- K_W, 8, width of k_len and of the operand-buffer addresses.
- PE_LAT, 5, PE multiply-accumulate pipeline latency in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request a tile; accepted only in IDLE.
- k_len  in  K_W  reduction length; sampled when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of tile.
- pe_clr  out  1  clears all PE accumulators.
- pe_en  out  1  advances the array (operand shift plus MAC).
- a_rd_en  out  N  per-row A-buffer read enable.
- a_rd_addr  out  N*K_W  per-row A address; row i occupies bits [i*K_W +: K_W].
- b_rd_en  out  N  per-column B-buffer read enable.
- b_rd_addr  out  N*K_W  per-column B address; same packing as a_rd_addr.
- out_valid  out  1  a result row is presented.
- out_row  out  $clog2(N)  index of the presented row.
- out_ready  in  1  consumer accepts the row.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE;
  - all outputs are 0;
  - all counters are 0.
  - This applies mid-operation too: any in-flight tile is abandoned with no done pulse.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> READOUT -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_len.
  - k_len=0 goes directly to DONE: no clear, no reads, no pe_en.
  - Otherwise goes to CLEAR.
- CLEAR: one cycle, pe_clr=1.
- FEED: lasts k_len+N-1 cycles; pe_en=1 throughout. With t the feed cycle (0-based):
  - a_rd_en[i]=1 iff i <= t < i+k_len, with a_rd_addr[i]=t-i.
  - b_rd_en[j] follows the same rule with j.
  - When an enable is low its address is 0; the array datapath injects +0.0 (32'h0) on that lane.
- DRAIN: lasts D = 2*(N-1)+PE_LAT cycles; pe_en=1 and all read enables are 0.
- READOUT:
  - out_valid=1 with out_row=r, starting at r=0.
  - r advances on out_valid && out_ready.
  - out_row holds stable while out_ready=0.
  - After acceptance of row N-1, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in all states except IDLE.
- start outside IDLE is ignored; it is not queued.
- Counter width: FEED/DRAIN counter is K_W+$clog2(N)+1 bits, so k_len=2^K_W-1 does not wrap.

Optional Feature:
- Macro: SYSTOLIC_STALL_EN.
- Defined:
  - adds input port stall (1 bit);
  - while stall=1 in FEED or DRAIN: pe_en=0, read enables=0, and the FEED/DRAIN counters freeze;
  - stall is ignored in all other states.
- Undefined: no stall port; the array advances every cycle in FEED/DRAIN.

Decomposition:
- Package systolic_pkg holds:
  - state enum ctrl_state_t;
  - FP_ZERO constant (32'h0);
  - function drain_len(N, PE_LAT) returning 2*(N-1)+PE_LAT.
- Sub-module systolic_skew_lane:
  - one instance per row and one per column;
  - inputs: feed counter, lane index, k_len;
  - outputs: rd_en and rd_addr;
  - purely combinational.
- The FSM and counters live in systolic_ctrl.

Test Plan (all with N=4, PE_LAT=5):
- Basic tile: start at cycle 0 with k_len=3 and out_ready held at 1 ->
  - pe_clr at cycle 1;
  - FEED at cycles 2-7;
  - row 0 addresses 0,1,2 at cycles 2-4; row 3 addresses 0,1,2 at cycles 5-7;
  - DRAIN at cycles 8-18;
  - out_row 0..3 at cycles 19-22;
  - done at cycle 23; busy low at cycle 24.
- Zero length: k_len=0 with start -> done at cycle 1; pe_clr, pe_en and all rd_en stay 0.
- Backpressure: out_ready=0 for 3 cycles on row 1 -> out_row holds at 1 with out_valid=1; done is delayed by 3 cycles.
- Reset mid-FEED: rst=0 at cycle 4 of the basic tile ->
  - all outputs go to 0 immediately (asynchronous);
  - no done pulse;
  - a new start after reset release runs the full basic-tile sequence.
- Ignored start: start pulses during DRAIN -> no effect; exactly one done; state returns to IDLE.
- SYSTOLIC_STALL_EN: stall=1 for 2 cycles in mid-FEED -> pe_en=0 and rd_en=0 in those cycles; addresses resume in sequence; done at cycle 25.
